// File: rtl/sim_tohost_monitor_if.sv
// Data-memory write port and retire lanes as seen by the tohost monitor.
interface sim_tohost_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int NRET   = 1
);
    logic              dmem_wvalid;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [31:0]       dmem_wdata;
    logic [NRET-1:0]   retire;

    modport master (
        output dmem_wvalid,
        output dmem_waddr,
        output dmem_wdata,
        output retire
    );

    modport slave (
        input dmem_wvalid,
        input dmem_waddr,
        input dmem_wdata,
        input retire
    );
endinterface

// File: rtl/sim_tohost_monitor.sv
// Tohost monitor: console chars, finish/exit code, counter snapshots,
// cycle/instret counters, post-finish drain and optional watchdog.
module sim_tohost_monitor #(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h4000_0000,
    parameter int              NRET         = 1,
    parameter int              CNT_W        = 64,
    parameter int              FINISH_DELAY = 2,
    parameter int              TIMEOUT      = 0
) (
    input  logic               aclk_i,
    input  logic               areset_ni,
    sim_tohost_monitor_if.slave bus,
    output logic               putc_valid_o,
    output logic [7:0]         putc_char_o,
    output logic               snap_valid_o,
    output logic [CNT_W-1:0]   snap_cycle_o,
    output logic [CNT_W-1:0]   snap_instret_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic [CNT_W-1:0]   instret_o,
    output logic               done_o,
    output logic [15:0]        exit_code_o,
    output logic               pass_o,
    output logic               timeout_o
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    localparam int DW = (FINISH_DELAY > 1) ? $clog2(FINISH_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              putc_valid_q, putc_valid_d;
    logic [7:0]        putc_char_q, putc_char_d;
    logic              snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]  snap_cycle_q, snap_cycle_d;
    logic [CNT_W-1:0]  snap_instret_q, snap_instret_d;
    logic [15:0]       exit_code_q, exit_code_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic              acc;
    logic [1:0]        cmd;
    logic              active;
    logic [CNT_W-1:0]  pop;

    wire unused_ok = &{1'b0, bus.dmem_wdata[31:18]};

    assign acc    = bus.dmem_wvalid && (bus.dmem_waddr == TOHOST_ADDR);
    assign cmd    = bus.dmem_wdata[17:16];
    assign active = (state_q != DONE);

    always_comb begin
        pop = '0;
        for (int i = 0; i < NRET; i++) begin
            pop = pop + CNT_W'(bus.retire[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        cycle_d        = cycle_q;
        instret_d      = instret_q;
        putc_valid_d   = 1'b0;
        putc_char_d    = putc_char_q;
        snap_valid_d   = 1'b0;
        snap_cycle_d   = snap_cycle_q;
        snap_instret_d = snap_instret_q;
        exit_code_d    = exit_code_q;
        done_d         = done_q;
        pass_d         = pass_q;
        timeout_d      = timeout_q;

        if (active) begin
            cycle_d   = cycle_q + 1'b1;
            instret_d = instret_q + pop;
            if (acc && cmd == 2'b01) begin
                putc_valid_d = 1'b1;
                putc_char_d  = bus.dmem_wdata[7:0];
            end
            if (acc && cmd == 2'b11) begin
                snap_valid_d   = 1'b1;
                snap_cycle_d   = cycle_q;
                snap_instret_d = instret_q;
            end
        end

        unique case (state_q)
            RUN: begin
                if (acc && cmd == 2'b10) begin
                    exit_code_d = bus.dmem_wdata[15:0];
                    if (FINISH_DELAY == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (bus.dmem_wdata[15:0] == 16'h0);
                    end else begin
                        state_d = DRAIN;
                        drain_d = DW'(FINISH_DELAY);
                    end
                end else if (TIMEOUT != 0 && cycle_q == TO_M1) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    exit_code_d = 16'hFFFF;
                    pass_d      = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q <= DW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (exit_code_q == 16'h0);
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (!areset_ni) begin
            state_q        <= RUN;
            drain_q        <= '0;
            cycle_q        <= '0;
            instret_q      <= '0;
            putc_valid_q   <= 1'b0;
            putc_char_q    <= '0;
            snap_valid_q   <= 1'b0;
            snap_cycle_q   <= '0;
            snap_instret_q <= '0;
            exit_code_q    <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            cycle_q        <= cycle_d;
            instret_q      <= instret_d;
            putc_valid_q   <= putc_valid_d;
            putc_char_q    <= putc_char_d;
            snap_valid_q   <= snap_valid_d;
            snap_cycle_q   <= snap_cycle_d;
            snap_instret_q <= snap_instret_d;
            exit_code_q    <= exit_code_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_q      <= timeout_d;
        end
    end

    assign putc_valid_o   = putc_valid_q;
    assign putc_char_o    = putc_char_q;
    assign snap_valid_o   = snap_valid_q;
    assign snap_cycle_o   = snap_cycle_q;
    assign snap_instret_o = snap_instret_q;
    assign cycle_o        = cycle_q;
    assign instret_o      = instret_q;
    assign done_o         = done_q;
    assign exit_code_o    = exit_code_q;
    assign pass_o         = pass_q;
    assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_sim_tohost_monitor.sv
// Directed bench: four monitor configurations share one write bus,
// each exercised in turn while the others sit in reset.
module tb_sim_tohost_monitor;
    localparam logic [31:0] TH = 32'h4000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;

    sim_tohost_monitor_if #(.ADDR_W(32), .NRET(2)) bus ();

    // A: FINISH_DELAY=2, no watchdog
    logic        a_pv, a_sv, a_done, a_pass, a_to;
    logic [7:0]  a_pc;
    logic [63:0] a_sc, a_si, a_cyc, a_ins;
    logic [15:0] a_ec;
    sim_tohost_monitor #(.NRET(2), .FINISH_DELAY(2), .TIMEOUT(0)) u_a (
        .aclk_i(clk), .areset_ni(rst_a), .bus(bus),
        .putc_valid_o(a_pv), .putc_char_o(a_pc),
        .snap_valid_o(a_sv), .snap_cycle_o(a_sc), .snap_instret_o(a_si),
        .cycle_o(a_cyc), .instret_o(a_ins), .done_o(a_done),
        .exit_code_o(a_ec), .pass_o(a_pass), .timeout_o(a_to));

    // B: watchdog at 20 cycles
    logic        b_pv, b_sv, b_done, b_pass, b_to;
    logic [7:0]  b_pc;
    logic [63:0] b_sc, b_si, b_cyc, b_ins;
    logic [15:0] b_ec;
    sim_tohost_monitor #(.NRET(2), .FINISH_DELAY(2), .TIMEOUT(20)) u_b (
        .aclk_i(clk), .areset_ni(rst_b), .bus(bus),
        .putc_valid_o(b_pv), .putc_char_o(b_pc),
        .snap_valid_o(b_sv), .snap_cycle_o(b_sc), .snap_instret_o(b_si),
        .cycle_o(b_cyc), .instret_o(b_ins), .done_o(b_done),
        .exit_code_o(b_ec), .pass_o(b_pass), .timeout_o(b_to));

    // C: no drain
    logic        c_pv, c_sv, c_done, c_pass, c_to;
    logic [7:0]  c_pc;
    logic [63:0] c_sc, c_si, c_cyc, c_ins;
    logic [15:0] c_ec;
    sim_tohost_monitor #(.NRET(2), .FINISH_DELAY(0), .TIMEOUT(0)) u_c (
        .aclk_i(clk), .areset_ni(rst_c), .bus(bus),
        .putc_valid_o(c_pv), .putc_char_o(c_pc),
        .snap_valid_o(c_sv), .snap_cycle_o(c_sc), .snap_instret_o(c_si),
        .cycle_o(c_cyc), .instret_o(c_ins), .done_o(c_done),
        .exit_code_o(c_ec), .pass_o(c_pass), .timeout_o(c_to));

    // D: 4-bit counters
    logic        d_pv, d_sv, d_done, d_pass, d_to;
    logic [7:0]  d_pc;
    logic [3:0]  d_sc, d_si, d_cyc, d_ins;
    logic [15:0] d_ec;
    sim_tohost_monitor #(.NRET(2), .CNT_W(4), .FINISH_DELAY(2)) u_d (
        .aclk_i(clk), .areset_ni(rst_d), .bus(bus),
        .putc_valid_o(d_pv), .putc_char_o(d_pc),
        .snap_valid_o(d_sv), .snap_cycle_o(d_sc), .snap_instret_o(d_si),
        .cycle_o(d_cyc), .instret_o(d_ins), .done_o(d_done),
        .exit_code_o(d_ec), .pass_o(d_pass), .timeout_o(d_to));

    int n_pass = 0;
    int n_tot  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.dmem_wvalid = 1'b1;
        bus.dmem_waddr  = addr;
        bus.dmem_wdata  = data;
    endtask

    task automatic idle();
        bus.dmem_wvalid = 1'b0;
        bus.dmem_waddr  = '0;
        bus.dmem_wdata  = '0;
    endtask

    initial begin
        idle();
        bus.retire = 2'b11;

        // reset state
        tick();
        chk("rst_cycle", a_cyc, 0);
        chk("rst_done", {63'd0, a_done}, 0);
        chk("rst_putc", {63'd0, a_pv}, 0);
        chk("rst_exit", {48'd0, a_ec}, 0);

        // idle counting
        rst_a = 1'b1;
        tick(10);
        chk("idle_cycle", a_cyc, 10);
        chk("idle_instret", a_ins, 20);
        chk("idle_done", {63'd0, a_done}, 0);
        chk("idle_putc", {63'd0, a_pv}, 0);
        chk("idle_snap", {63'd0, a_sv}, 0);

        // back-to-back putc
        wr(TH, 32'h0001_0048);
        tick();
        chk("putc0_v", {63'd0, a_pv}, 1);
        chk("putc0_c", {56'd0, a_pc}, 64'h48);
        wr(TH, 32'h0001_0069);
        tick();
        chk("putc1_v", {63'd0, a_pv}, 1);
        chk("putc1_c", {56'd0, a_pc}, 64'h69);
        wr(TH + 32'h4, 32'h0001_0041);
        tick();
        chk("otheraddr_v", {63'd0, a_pv}, 0);
        chk("otheraddr_c", {56'd0, a_pc}, 64'h69);
        wr(TH, 32'h0000_0041);
        tick();
        chk("cmd0_v", {63'd0, a_pv}, 0);
        idle();

        // snapshot at 5, finish at 8
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        tick(5);
        wr(TH, 32'h0003_0000);
        tick();
        chk("snap_v", {63'd0, a_sv}, 1);
        chk("snap_cyc", a_sc, 5);
        chk("snap_ins", a_si, 10);
        idle();
        tick(2);
        chk("pre_fin_cyc", a_cyc, 8);
        wr(TH, 32'h0002_0000);
        tick();
        idle();
        chk("drain1_done", {63'd0, a_done}, 0);
        tick();
        chk("drain2_done", {63'd0, a_done}, 0);
        tick();
        chk("fin_done", {63'd0, a_done}, 1);
        chk("fin_cyc", a_cyc, 11);
        chk("fin_pass", {63'd0, a_pass}, 1);
        chk("fin_exit", {48'd0, a_ec}, 0);
        tick(2);
        chk("frozen_cyc", a_cyc, 11);
        chk("frozen_ins", a_ins, 22);

        // exit code held through DRAIN, putc in DRAIN, none after DONE
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        wr(TH, 32'h0002_0007);
        tick();
        wr(TH, 32'h0002_0000);
        tick();
        wr(TH, 32'h0001_0041);
        tick();
        chk("drain_putc_v", {63'd0, a_pv}, 1);
        chk("drain_putc_c", {56'd0, a_pc}, 64'h41);
        chk("ec7_done", {63'd0, a_done}, 1);
        chk("ec7_exit", {48'd0, a_ec}, 7);
        chk("ec7_pass", {63'd0, a_pass}, 0);
        wr(TH, 32'h0001_0042);
        tick();
        chk("done_putc_v", {63'd0, a_pv}, 0);
        chk("done_putc_c", {56'd0, a_pc}, 64'h41);
        idle();

        // reset during DRAIN
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        wr(TH, 32'h0002_0005);
        tick();
        idle();
        rst_a = 1'b0;
        tick();
        chk("rstdr_cyc", a_cyc, 0);
        chk("rstdr_exit", {48'd0, a_ec}, 0);
        chk("rstdr_done", {63'd0, a_done}, 0);

        // finish with no drain
        rst_c = 1'b1;
        wr(TH, 32'h0002_0000);
        tick();
        idle();
        chk("fd0_done", {63'd0, c_done}, 1);
        chk("fd0_pass", {63'd0, c_pass}, 1);
        chk("fd0_cyc", c_cyc, 1);

        // watchdog fires
        rst_b = 1'b1;
        tick(19);
        chk("wd19_done", {63'd0, b_done}, 0);
        tick();
        chk("wd_done", {63'd0, b_done}, 1);
        chk("wd_to", {63'd0, b_to}, 1);
        chk("wd_exit", {48'd0, b_ec}, 64'hFFFF);
        chk("wd_cyc", b_cyc, 20);
        chk("wd_pass", {63'd0, b_pass}, 0);

        // finish on the watchdog cycle wins
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick(19);
        chk("wdf_pre", b_cyc, 19);
        wr(TH, 32'h0002_0000);
        tick();
        idle();
        chk("wdf_done", {63'd0, b_done}, 0);
        chk("wdf_to", {63'd0, b_to}, 0);
        tick(2);
        chk("wdf_done2", {63'd0, b_done}, 1);
        chk("wdf_to2", {63'd0, b_to}, 0);
        chk("wdf_pass", {63'd0, b_pass}, 1);
        chk("wdf_cyc", b_cyc, 22);

        // 4-bit counter wrap
        rst_d = 1'b1;
        tick(17);
        chk("wrap_cyc", {60'd0, d_cyc}, 1);
        chk("wrap_ins", {60'd0, d_ins}, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
